// File: rtl/sobel_window_ctrl.sv
// Raster-stream sequencer for a 3x3 Sobel kernel: two line buffers, a 3x3 shift array
// and a one-deep window register with valid/ready handshakes on both sides.
module sobel_window_ctrl #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned PIX_W = 8,
    parameter int unsigned XW    = 10
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [PIX_W-1:0]   in_pixel,
    output logic               win_valid,
    input  logic               win_ready,
    output logic [9*PIX_W-1:0] win_data,
    output logic [XW-1:0]      win_col,
    output logic [XW-1:0]      win_row,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [1:0] {StIdle, StStream, StDrain, StDone} state_e;

    localparam int unsigned   AW      = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [XW-1:0] ColLast = XW'(IMG_W - 1);
    localparam logic [XW-1:0] RowLast = XW'(IMG_H - 1);

    state_e               state_q, state_d;
    logic [XW-1:0]        col_q, col_d, row_q, row_d;
    logic [PIX_W-1:0]     sh_q [9];
    logic [PIX_W-1:0]     sh_d [9];
    logic                 win_valid_q, win_valid_d;
    logic [9*PIX_W-1:0]   win_data_q, win_data_d;
    logic [XW-1:0]        win_col_q, win_col_d, win_row_q, win_row_d;
    logic                 busy_q, busy_d, done_q, done_d;

    logic [PIX_W-1:0]     lb0_q [IMG_W];
    logic [PIX_W-1:0]     lb1_q [IMG_W];

    logic                 accept, emit;
    logic [AW-1:0]        laddr;

    assign in_ready = (state_q == StStream) && (!win_valid_q || win_ready);
    assign accept   = in_valid && in_ready;
    assign emit     = accept && (col_q >= XW'(2)) && (row_q >= XW'(2));
    assign laddr    = col_q[AW-1:0];

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        sh_d        = sh_q;
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StStream;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            StStream: begin
                if (accept) begin
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + XW'(1);
                        end
                    end else begin
                        col_d = col_q + XW'(1);
                    end
                end
            end
            StDrain: begin
                if (!win_valid_q || win_ready) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Shift left; the new right column is the vertical slice ending at the incoming pixel.
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                sh_d[3*r]     = sh_q[3*r+1];
                sh_d[3*r+1]   = sh_q[3*r+2];
            end
            sh_d[2] = lb1_q[laddr];
            sh_d[5] = lb0_q[laddr];
            sh_d[8] = in_pixel;
        end

        // A load wins over a consume in the same cycle, so back-to-back windows have no bubble.
        if (emit) begin
            win_valid_d = 1'b1;
            for (int i = 0; i < 9; i++) begin
                win_data_d[(8-i)*PIX_W +: PIX_W] = sh_d[i];
            end
            win_col_d = col_q - XW'(1);
            win_row_d = row_q - XW'(1);
        end else if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
            win_data_d  = '0;
            win_col_d   = '0;
            win_row_d   = '0;
        end

        busy_d = (state_d == StStream) || (state_d == StDrain);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            col_q       <= '0;
            row_q       <= '0;
            for (int i = 0; i < 9; i++) begin
                sh_q[i] <= '0;
            end
            win_valid_q <= 1'b0;
            win_data_q  <= '0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            sh_q        <= sh_d;
            win_valid_q <= win_valid_d;
            win_data_q  <= win_data_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // Line buffers are always written before being read for a window, so they carry no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb1_q[laddr] <= lb0_q[laddr];
            lb0_q[laddr] <= in_pixel;
        end
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign win_col    = win_col_q;
    assign win_row    = win_row_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule
